// File: rtl/xc20xx_cfg_loader_if.sv
// Serial configuration port bundle for the XC20XX configuration loader.
//   master : bitstream source, drives DIN/BIT_EN and observes frame/status outputs
//   slave  : the loader, consumes DIN/BIT_EN and drives frame/status outputs
// Signals:
//   DIN         serial configuration bit
//   BIT_EN      DIN is valid and consumed on this clock edge
//   FRAME_DATA  last completed frame, first data bit received at MSB
//   FRAME_ADDR  index of FRAME_DATA
//   FRAME_VALID one-cycle pulse per completed frame
//   LEN         captured length count
//   DONE        configuration complete (sticky)
//   ERR         format error (sticky)
interface xc20xx_cfg_loader_if #(
    parameter int FRAME_BITS = 71,
    parameter int LEN_BITS   = 24,
    parameter int ADDR_W     = 8
);
    logic                  DIN;
    logic                  BIT_EN;
    logic [FRAME_BITS-1:0] FRAME_DATA;
    logic [ADDR_W-1:0]     FRAME_ADDR;
    logic                  FRAME_VALID;
    logic [LEN_BITS-1:0]   LEN;
    logic                  DONE;
    logic                  ERR;

    modport master (
        output DIN, BIT_EN,
        input  FRAME_DATA, FRAME_ADDR, FRAME_VALID, LEN, DONE, ERR
    );

    modport slave (
        input  DIN, BIT_EN,
        output FRAME_DATA, FRAME_ADDR, FRAME_VALID, LEN, DONE, ERR
    );
endinterface

// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader for the XC20XX fabric model. Deserialises a
// bitstream made of a 0010 preamble, a length count and framed data
// (start bit 0, FRAME_BITS data bits MSB-first, three stop bits 1) and
// presents each completed frame with its index to the frame memory.
// Ports:
//   K    clock, all state updates on the rising edge
//   R_N  synchronous active-low reset
//   cfg  slave side of xc20xx_cfg_loader_if (DIN/BIT_EN in, frame/status out)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | searching for the 0,0,1,0 preamble in accepted bits
// ST_LENGTH | shifting in LEN_BITS of length count, MSB first
// ST_START  | expecting the frame start bit (0)
// ST_DATA   | shifting FRAME_BITS data bits into the staging register
// ST_STOP   | expecting three stop bits (1); third one commits the frame
// ST_TAIL   | all frames done, counting ignored tail bits up to LEN
// ST_DONE   | configuration complete, terminal until reset
// ST_ERROR  | format error, terminal until reset
module xc20xx_cfg_loader #(
    parameter int FRAME_BITS = 71,
    parameter int NUM_FRAMES = 160,
    parameter int LEN_BITS   = 24,
    parameter int ADDR_W     = 8
) (
    input logic                K,
    input logic                R_N,
    xc20xx_cfg_loader_if.slave cfg
);

    localparam logic [31:0] REQ    = 32'(NUM_FRAMES * (FRAME_BITS + 4));
    localparam int          BC_MAX = (LEN_BITS > FRAME_BITS) ? LEN_BITS : FRAME_BITS;
    localparam int          BC_W   = $clog2(BC_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LENGTH,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_TAIL,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t state, state_nxt;

    logic [3:0]            hist;
    logic [1:0]            hist_fill;
    logic [BC_W-1:0]       bit_left;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS-1:0]   cnt;
    logic [ADDR_W-1:0]     frame_idx;
    logic [FRAME_BITS-1:0] stage;
    logic [FRAME_BITS-1:0] frame_data_q;
    logic [ADDR_W-1:0]     frame_addr_q;
    logic                  frame_valid_q;

    logic                  acc;
    logic [3:0]            hist_shift;
    logic                  preamble_hit;
    logic [LEN_BITS-1:0]   len_shift;
    logic                  len_short;
    logic [LEN_BITS-1:0]   cnt_inc;
    logic                  hits_len;
    logic                  bit_tc;
    logic                  last_frame;

    assign acc          = cfg.BIT_EN;
    assign hist_shift   = {hist[2:0], cfg.DIN};
    // hist_fill == 3 means three earlier bits are in hist, so together with
    // the current bit a full four-bit window has been seen.
    assign preamble_hit = (hist_fill == 2'd3) && (hist_shift == 4'b0010);
    assign len_shift    = {len_q[LEN_BITS-2:0], cfg.DIN};
    assign len_short    = 32'(len_shift) < REQ;
    assign cnt_inc      = cnt + LEN_BITS'(1);
    assign hits_len     = (cnt_inc == len_q);
    assign bit_tc       = (bit_left == '0);
    assign last_frame   = (frame_idx == ADDR_W'(NUM_FRAMES - 1));

    always_ff @(posedge K) begin
        if (!R_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            case (state)
                ST_IDLE:   if (preamble_hit) state_nxt = ST_LENGTH;
                ST_LENGTH: if (bit_tc) state_nxt = len_short ? ST_ERROR : ST_START;
                ST_START:  state_nxt = cfg.DIN ? ST_ERROR : ST_DATA;
                ST_DATA:   if (bit_tc) state_nxt = ST_STOP;
                ST_STOP: begin
                    if (!cfg.DIN) begin
                        state_nxt = ST_ERROR;
                    end else if (bit_tc) begin
                        if (!last_frame)   state_nxt = ST_START;
                        else if (hits_len) state_nxt = ST_DONE;
                        else               state_nxt = ST_TAIL;
                    end
                end
                ST_TAIL:   if (hits_len) state_nxt = ST_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        cfg.DONE = (state == ST_DONE);
        cfg.ERR  = (state == ST_ERROR);
    end

    always_ff @(posedge K) begin
        if (!R_N) begin
            hist          <= '0;
            hist_fill     <= '0;
            bit_left      <= '0;
            len_q         <= '0;
            cnt           <= '0;
            frame_idx     <= '0;
            stage         <= '0;
            frame_data_q  <= '0;
            frame_addr_q  <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (acc) begin
                case (state)
                    ST_IDLE: begin
                        hist     <= hist_shift;
                        bit_left <= BC_W'(LEN_BITS - 1);
                        if (hist_fill != 2'd3) hist_fill <= hist_fill + 2'd1;
                    end
                    ST_LENGTH: begin
                        len_q    <= len_shift;
                        bit_left <= bit_left - BC_W'(1);
                        if (bit_tc) begin
                            cnt       <= '0;
                            frame_idx <= '0;
                        end
                    end
                    ST_START: begin
                        cnt      <= cnt_inc;
                        bit_left <= BC_W'(FRAME_BITS - 1);
                    end
                    ST_DATA: begin
                        cnt      <= cnt_inc;
                        stage    <= {stage[FRAME_BITS-2:0], cfg.DIN};
                        bit_left <= bit_tc ? BC_W'(2) : bit_left - BC_W'(1);
                    end
                    ST_STOP: begin
                        cnt      <= cnt_inc;
                        bit_left <= bit_left - BC_W'(1);
                        if (bit_tc && cfg.DIN) begin
                            frame_data_q  <= stage;
                            frame_addr_q  <= frame_idx;
                            frame_valid_q <= 1'b1;
                            frame_idx     <= frame_idx + ADDR_W'(1);
                        end
                    end
                    ST_TAIL: cnt <= cnt_inc;
                    default: ;
                endcase
            end
        end
    end

    assign cfg.FRAME_DATA  = frame_data_q;
    assign cfg.FRAME_ADDR  = frame_addr_q;
    assign cfg.FRAME_VALID = frame_valid_q;
    assign cfg.LEN         = len_q;

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
module tb_xc20xx_cfg_loader;
    localparam int FB = 8;
    localparam int NF = 2;
    localparam int LB = 8;
    localparam int AW = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [FB-1:0] data;
        logic          done;
    } exp_t;

    logic K;
    logic R_N;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    bit   stream[$];
    logic acc_q = 1'b0;

    xc20xx_cfg_loader_if #(.FRAME_BITS(FB), .LEN_BITS(LB), .ADDR_W(AW)) cfg ();

    xc20xx_cfg_loader #(
        .FRAME_BITS(FB), .NUM_FRAMES(NF), .LEN_BITS(LB), .ADDR_W(AW)
    ) dut (
        .K   (K),
        .R_N (R_N),
        .cfg (cfg.slave)
    );

    initial K = 1'b0;
    always #5 K = ~K;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept-edge tracker so the monitor can tell gap cycles from bit cycles.
    always @(posedge K) acc_q = cfg.BIT_EN & R_N;

    // Scoreboard monitor: every FRAME_VALID pops one expected frame.
    always @(negedge K) begin
        if (cfg.FRAME_VALID) begin
            chk("valid_after_accept", 32'(acc_q), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_valid", 32'(cfg.FRAME_ADDR), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_addr", 32'(cfg.FRAME_ADDR), 32'(e.addr));
                chk("frame_data", 32'(cfg.FRAME_DATA), 32'(e.data));
                chk("done_with_frame", 32'(cfg.DONE), 32'(e.done));
            end
        end
        if (cfg.DONE || cfg.ERR)
            chk("done_err_exclusive", 32'(cfg.DONE & cfg.ERR), 32'd0);
    end

    task automatic expect_frame(input logic [AW-1:0] a, input logic [FB-1:0] d, input logic dn);
        exp_t e;
        e.addr = a; e.data = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic add(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
    endtask

    task automatic add_frame(input logic [FB-1:0] d);
        add(32'd0, 1);
        add(32'(d), FB);
        add(32'b111, 3);
    endtask

    task automatic build_std(input logic [LB-1:0] len);
        stream.delete();
        add(32'hF, 4);
        add(32'b0010, 4);
        add(32'(len), LB);
        add_frame(8'hA5);
        add_frame(8'h3C);
    endtask

    task automatic send_bit(input bit b);
        cfg.DIN    = b;
        cfg.BIT_EN = 1'b1;
        @(posedge K);
        #1;
        cfg.BIT_EN = 1'b0;
    endtask

    task automatic idle(input int n);
        cfg.BIT_EN = 1'b0;
        repeat (n) @(posedge K);
        #1;
    endtask

    task automatic play(input bit gaps);
        foreach (stream[i]) begin
            if (gaps) begin
                int r;
                r = $urandom_range(0, 3);
                if (r == 0)      idle(5);
                else if (r == 1) idle(1);
            end
            send_bit(stream[i]);
        end
    endtask

    // Let the monitor see the last pulse, then require the scoreboard drained.
    task automatic drain(input string name);
        @(negedge K);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  32'(cfg.FRAME_DATA),  32'd0);
        chk({tag, "_addr"},  32'(cfg.FRAME_ADDR),  32'd0);
        chk({tag, "_valid"}, 32'(cfg.FRAME_VALID), 32'd0);
        chk({tag, "_len"},   32'(cfg.LEN),         32'd0);
        chk({tag, "_done"},  32'(cfg.DONE),        32'd0);
        chk({tag, "_err"},   32'(cfg.ERR),         32'd0);
    endtask

    task automatic do_reset();
        drain("scoreboard_empty_before_reset");
        R_N        = 1'b0;
        cfg.BIT_EN = 1'b0;
        @(posedge K);
        #1;
        R_N = 1'b1;
    endtask

    task automatic check_done_ok(input string tag);
        chk({tag, "_done"}, 32'(cfg.DONE), 32'd1);
        chk({tag, "_err"},  32'(cfg.ERR),  32'd0);
        chk({tag, "_len"},  32'(cfg.LEN),  32'h18);
    endtask

    initial begin
        R_N        = 1'b0;
        cfg.DIN    = 1'b0;
        cfg.BIT_EN = 1'b0;
        repeat (2) @(posedge K);
        #1;
        check_zero("reset");
        R_N = 1'b1;

        // Nominal load, LEN == REQ: DONE together with second commit.
        build_std(8'h18);
        expect_frame(2'd0, 8'hA5, 1'b0);
        expect_frame(2'd1, 8'h3C, 1'b1);
        play(1'b0);
        check_done_ok("nominal");

        // Tail bits: DONE exactly on the third tail bit.
        do_reset();
        build_std(8'h1B);
        expect_frame(2'd0, 8'hA5, 1'b0);
        expect_frame(2'd1, 8'h3C, 1'b0);
        play(1'b0);
        chk("tail_done_after_frames", 32'(cfg.DONE), 32'd0);
        send_bit(1'b1);
        chk("tail_done_bit1", 32'(cfg.DONE), 32'd0);
        send_bit(1'b1);
        chk("tail_done_bit2", 32'(cfg.DONE), 32'd0);
        send_bit(1'b1);
        chk("tail_done_bit3", 32'(cfg.DONE), 32'd1);
        chk("tail_len", 32'(cfg.LEN), 32'h1B);

        // Gapped input.
        do_reset();
        build_std(8'h18);
        expect_frame(2'd0, 8'hA5, 1'b0);
        expect_frame(2'd1, 8'h3C, 1'b1);
        idle(5);
        play(1'b1);
        check_done_ok("gapped");

        // Start bit 1 in frame 1.
        do_reset();
        build_std(8'h18);
        for (int i = 0; i < FB + 4; i++) void'(stream.pop_back());
        expect_frame(2'd0, 8'hA5, 1'b0);
        play(1'b0);
        chk("badstart_err_before", 32'(cfg.ERR), 32'd0);
        send_bit(1'b1);
        chk("badstart_err", 32'(cfg.ERR), 32'd1);
        chk("badstart_data", 32'(cfg.FRAME_DATA), 32'hA5);
        chk("badstart_addr", 32'(cfg.FRAME_ADDR), 32'd0);
        chk("badstart_done", 32'(cfg.DONE), 32'd0);
        stream.delete();
        add(32'h3C, 8);
        add(32'b111, 3);
        play(1'b0);
        chk("badstart_err_sticky", 32'(cfg.ERR), 32'd1);
        chk("badstart_data_held", 32'(cfg.FRAME_DATA), 32'hA5);

        // Stop bit 0 in frame 0.
        do_reset();
        stream.delete();
        add(32'hF, 4);
        add(32'b0010, 4);
        add(32'h18, LB);
        add(32'd0, 1);
        add(32'hA5, FB);
        add(32'b1, 1);
        play(1'b0);
        chk("badstop_err_before", 32'(cfg.ERR), 32'd0);
        send_bit(1'b0);
        chk("badstop_err", 32'(cfg.ERR), 32'd1);
        chk("badstop_done", 32'(cfg.DONE), 32'd0);
        chk("badstop_data", 32'(cfg.FRAME_DATA), 32'd0);

        // Short length count.
        do_reset();
        stream.delete();
        add(32'hF, 4);
        add(32'b0010, 4);
        add(32'b0001000, 7);
        play(1'b0);
        chk("shortlen_err_before", 32'(cfg.ERR), 32'd0);
        send_bit(1'b0);
        chk("shortlen_err", 32'(cfg.ERR), 32'd1);
        chk("shortlen_len", 32'(cfg.LEN), 32'h10);
        chk("shortlen_done", 32'(cfg.DONE), 32'd0);

        // Reset in the middle of frame 1 data, then full replay.
        do_reset();
        build_std(8'h18);
        for (int i = 0; i < 7; i++) void'(stream.pop_back());
        expect_frame(2'd0, 8'hA5, 1'b0);
        play(1'b0);
        drain("midreset_frame0_seen");
        R_N        = 1'b0;
        cfg.DIN    = 1'b1;
        cfg.BIT_EN = 1'b1;
        @(posedge K);
        #1;
        R_N        = 1'b1;
        cfg.BIT_EN = 1'b0;
        check_zero("midreset");
        build_std(8'h18);
        expect_frame(2'd0, 8'hA5, 1'b0);
        expect_frame(2'd1, 8'h3C, 1'b1);
        play(1'b0);
        check_done_ok("replay");

        // Preamble search through a misleading prefix.
        do_reset();
        stream.delete();
        add(32'b11010010, 8);
        add(32'h18, LB);
        add_frame(8'hA5);
        add_frame(8'h3C);
        expect_frame(2'd0, 8'hA5, 1'b0);
        expect_frame(2'd1, 8'h3C, 1'b1);
        play(1'b0);
        check_done_ok("preamble");

        drain("scoreboard_empty_at_end");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
